// File: rtl/tx_path_pkg.sv
// tx_path_pkg: shared widths, state encoding and mode constants for the tx path switch
package tx_path_pkg;
  localparam int IQ_W = 16;
  localparam logic [1:0] ST_DAC = 2'd0;
  localparam logic [1:0] ST_MUTE = 2'd1;
  localparam logic [1:0] ST_LB = 2'd2;
  localparam logic MODE_DAC = 1'b0;
  localparam logic MODE_LB = 1'b1;
  typedef enum logic [1:0] {S_DAC = ST_DAC, S_MUTE = ST_MUTE, S_LB = ST_LB} state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous level into the clk domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  // shift the raw input through the chain; the last flop is the safe copy
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/tx_path_switch.sv
// tx_path_switch: steers modulator IQ to DAC or loopback with a zero-filled mute window on every switch (TXSW_DROP_CNT_EN adds odrop_cnt)
module tx_path_switch
  import tx_path_pkg::*;
#(
  parameter int MUTE_LEN = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IQ_W-1:0] iredata_tx,
  input  logic [IQ_W-1:0] iimdata_tx,
  input  logic            ivalid_tx,
  input  logic            switch_on,
  output logic [IQ_W-1:0] oredata_dac,
  output logic [IQ_W-1:0] oimdata_dac,
  output logic            ovalid_dac,
  output logic [IQ_W-1:0] oredata_lb,
  output logic [IQ_W-1:0] oimdata_lb,
  output logic            ovalid_lb,
  output logic            omode,
  output logic            obusy
`ifdef TXSW_DROP_CNT_EN
  ,output logic [15:0]    odrop_cnt
`endif
);
  localparam logic [7:0] LAST = 8'(MUTE_LEN - 1);
  state_t r_state, w_next;
  logic r_target, w_target, w_req;
  logic [7:0] r_cnt, w_cnt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .i_d(switch_on), .o_q(w_req));
  // next state: leave a stable path on a request change, re-arm the mute window if the request flips back
  always_comb begin
    w_next = r_state;
    w_target = r_target;
    w_cnt = r_cnt;
    if (r_state == S_DAC && w_req) begin
      w_next = S_MUTE;
      w_target = MODE_LB;
      w_cnt = '0;
    end else if (r_state == S_LB && !w_req) begin
      w_next = S_MUTE;
      w_target = MODE_DAC;
      w_cnt = '0;
    end else if (r_state == S_MUTE) begin
      if (w_req != r_target) begin
        w_target = w_req;
        w_cnt = '0;
      end else if (r_cnt == LAST) begin
        w_next = r_target == MODE_LB ? S_LB : S_DAC;
        w_cnt = '0;
      end else w_cnt = r_cnt + 8'd1;
    end
  end
  // routing follows the next state so a sample on the exit edge already takes the new path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_DAC;
      r_target <= MODE_DAC;
      r_cnt <= '0;
      oredata_dac <= '0;
      oimdata_dac <= '0;
      ovalid_dac <= 1'b0;
      oredata_lb <= '0;
      oimdata_lb <= '0;
      ovalid_lb <= 1'b0;
      omode <= MODE_DAC;
    end else begin
      r_state <= w_next;
      r_target <= w_target;
      r_cnt <= w_cnt;
      oredata_dac <= w_next == S_DAC ? iredata_tx : '0;
      oimdata_dac <= w_next == S_DAC ? iimdata_tx : '0;
      ovalid_dac <= ivalid_tx;
      oredata_lb <= w_next == S_LB ? iredata_tx : '0;
      oimdata_lb <= w_next == S_LB ? iimdata_tx : '0;
      ovalid_lb <= ivalid_tx && w_next == S_LB;
      if (w_next != S_MUTE) omode <= w_next == S_LB;
    end
  assign obusy = r_state == S_MUTE;
`ifdef TXSW_DROP_CNT_EN
  logic [15:0] r_drop;
  // count samples swallowed by the mute window, saturating
  always_ff @(posedge clk or posedge rst)
    if (rst) r_drop <= '0;
    else if (ivalid_tx && w_next == S_MUTE && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  assign odrop_cnt = r_drop;
`endif
endmodule

// File: tb/tb_tx_path_switch.sv
// tb_tx_path_switch: scoreboard bench for tx_path_switch driven by directed switch scenarios
module tb_tx_path_switch;
  logic clk, rst, ivalid_tx, switch_on;
  logic [15:0] iredata_tx, iimdata_tx;
  logic [15:0] oredata_dac, oimdata_dac, oredata_lb, oimdata_lb;
  logic ovalid_dac, ovalid_lb, omode, obusy;
`ifdef TXSW_DROP_CNT_EN
  logic [15:0] odrop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b1;
  logic [67:0] q[$];
  logic [67:0] w_got;
  tx_path_switch #(.MUTE_LEN(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .iredata_tx(iredata_tx), .iimdata_tx(iimdata_tx), .ivalid_tx(ivalid_tx),
    .switch_on(switch_on),
    .oredata_dac(oredata_dac), .oimdata_dac(oimdata_dac), .ovalid_dac(ovalid_dac),
    .oredata_lb(oredata_lb), .oimdata_lb(oimdata_lb), .ovalid_lb(ovalid_lb),
    .omode(omode), .obusy(obusy)
`ifdef TXSW_DROP_CNT_EN
    ,.odrop_cnt(odrop_cnt)
`endif
  );
  assign w_got = {oredata_dac, oimdata_dac, ovalid_dac, oredata_lb, oimdata_lb, ovalid_lb, omode, obusy};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (chk_en && !rst && (ovalid_dac || ovalid_lb)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid got %h with empty queue", w_got);
      end else begin
        logic [67:0] e;
        e = q.pop_front();
        if (w_got !== e) begin
          n_fail++;
          $display("FAIL sample got %h exp %h", w_got, e);
        end
      end
    end
  task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask
  task automatic cyc(input logic [15:0] re, input logic [15:0] im, input logic v, input int route, input logic mode);
    iredata_tx = re;
    iimdata_tx = im;
    ivalid_tx = v;
    if (v) q.push_back(route == 0 ? {re, im, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0} :
                       route == 1 ? {32'h0, 1'b1, 32'h0, 1'b0, mode, 1'b1} :
                                    {32'h0, 1'b1, re, im, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    switch_on = 1'b0;
    iredata_tx = 16'h1234;
    iimdata_tx = 16'hABCD;
    ivalid_tx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", w_got, 68'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(16'h1234, 16'hABCD, 1'b1, 0, 1'b0);
    cyc(16'h0001, 16'hFFFF, 1'b1, 0, 1'b0);
    cyc(16'h5555, 16'hAAAA, 1'b0, 0, 1'b0);
    cyc(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
    for (int k = 0; k < 21; k++) begin
      if (k == 0) switch_on = 1'b1;
      cyc(k == 18 ? 16'h7FFF : 16'(4096 + k), k == 18 ? 16'h8000 : 16'(8192 + k), 1'b1,
          k < 2 ? 0 : k < 18 ? 1 : 2, 1'b0);
    end
    chk("mode_after_to_lb", {67'h0, omode}, 68'h1);
    for (int k = 0; k < 21; k++) begin
      if (k == 0) switch_on = 1'b0;
      cyc(16'(12288 + k), 16'(16384 + k), 1'b1, k < 2 ? 2 : k < 18 ? 1 : 0, 1'b1);
    end
    chk("mode_after_to_dac", {66'h0, omode, ovalid_lb}, 68'h0);
    for (int k = 0; k < 30; k++) begin
      if (k == 0) switch_on = 1'b1;
      if (k == 8) switch_on = 1'b0;
      cyc(16'(20480 + k), 16'(24576 + k), 1'b1, k < 2 ? 0 : k < 26 ? 1 : 0, 1'b0);
    end
    chk("abort_end_state", {66'h0, omode, obusy}, 68'h0);
    for (int k = 0; k < 11; k++) begin
      if (k == 0) switch_on = 1'b1;
      cyc(16'(28672 + k), 16'(-k - 1), 1'b1, k < 2 ? 0 : 1, 1'b0);
    end
    chk("busy_before_reset", {67'h0, obusy}, 68'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mid_mute", w_got, 68'h0);
    switch_on = 1'b0;
    ivalid_tx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_state", {66'h0, omode, obusy}, 68'h0);
    @(posedge clk);
    #1;
    cyc(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0);
    cyc(16'h7FFF, 16'h8000, 1'b1, 0, 1'b0);
`ifdef TXSW_DROP_CNT_EN
    for (int k = 0; k < 22; k++) begin
      if (k == 0) switch_on = 1'b1;
      cyc(16'(k + 1), 16'(k + 2), k % 2 == 0, k < 2 ? 0 : k < 18 ? 1 : 2, 1'b0);
    end
    chk("drop_cnt_8", {52'h0, odrop_cnt}, 68'd8);
    @(negedge clk);
    chk_en = 1'b0;
    ivalid_tx = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      switch_on = (i / 8) % 2 == 0 ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    chk("drop_cnt_sat", {52'h0, odrop_cnt}, 68'hFFFF);
`endif
    ivalid_tx = 1'b0;
    repeat (2) @(posedge clk);
    chk("queue_drained", 68'(q.size()), 68'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
